// File: rtl/rvh_mmu_pkg.sv
// Shared MMU constants: address/PTE field widths, TLB source codes and
// the miss-responder walk-ownership state encoding.
package rvh_mmu_pkg;

    localparam int unsigned MMU_VPN_WIDTH  = 27;
    localparam int unsigned MMU_PPN_WIDTH  = 44;
    localparam int unsigned MMU_ATTR_WIDTH = 8;

    typedef enum logic {
        TLB_SRC_D = 1'b0,
        TLB_SRC_I = 1'b1
    } tlb_src_e;

    typedef enum logic [1:0] {
        PTW_RSP_IDLE  = 2'd0,
        PTW_RSP_ISSUE = 2'd1,
        PTW_RSP_WAIT  = 2'd2,
        PTW_RSP_RESP  = 2'd3
    } ptw_rsp_state_e;

endpackage

// File: rtl/rvh_ptw_miss_responder.sv
// Walker-side end of the DTLB/ITLB miss path: owns the single outstanding
// page-table walk and routes its result back to the requesting TLB only.
module rvh_ptw_miss_responder
    import rvh_mmu_pkg::*;
#(
    parameter int unsigned VPN_WIDTH  = MMU_VPN_WIDTH,
    parameter int unsigned PPN_WIDTH  = MMU_PPN_WIDTH,
    parameter int unsigned ATTR_WIDTH = MMU_ATTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_i,
    input  logic                  dtlb_miss_req_vld_i,
    input  logic [VPN_WIDTH-1:0]  dtlb_miss_req_vpn_i,
    input  logic                  itlb_miss_req_vld_i,
    input  logic [VPN_WIDTH-1:0]  itlb_miss_req_vpn_i,
    output logic                  miss_req_rdy_o,
    output logic                  ptw_req_vld_o,
    output logic [VPN_WIDTH-1:0]  ptw_req_vpn_o,
    input  logic                  ptw_req_rdy_i,
    input  logic                  ptw_resp_vld_i,
    input  logic [PPN_WIDTH-1:0]  ptw_resp_ppn_i,
    input  logic [ATTR_WIDTH-1:0] ptw_resp_attr_i,
    input  logic [1:0]            ptw_resp_lvl_i,
    input  logic                  ptw_resp_fault_i,
    output logic                  dtlb_miss_resp_vld_o,
    output logic                  itlb_miss_resp_vld_o,
    output logic [PPN_WIDTH-1:0]  miss_resp_ppn_o,
    output logic [ATTR_WIDTH-1:0] miss_resp_attr_o,
    output logic [1:0]            miss_resp_lvl_o,
    output logic                  miss_resp_fault_o,
    output logic                  busy_o
);

    ptw_rsp_state_e        state_q, state_d;
    tlb_src_e              src_q;
    logic                  killed_q, killed_d;
    logic [VPN_WIDTH-1:0]  vpn_q;
    logic [PPN_WIDTH-1:0]  ppn_q;
    logic [ATTR_WIDTH-1:0] attr_q;
    logic [1:0]            lvl_q;
    logic                  fault_q;
    logic                  accept;
    logic                  resp_take;

    always_comb begin
        state_d              = state_q;
        killed_d             = killed_q;
        miss_req_rdy_o       = 1'b0;
        ptw_req_vld_o        = 1'b0;
        dtlb_miss_resp_vld_o = 1'b0;
        itlb_miss_resp_vld_o = 1'b0;
        accept               = 1'b0;
        resp_take            = 1'b0;
        case (state_q)
            PTW_RSP_IDLE: begin
                // Held low during reset so every output reads 0 while rstn is low.
                miss_req_rdy_o = rstn & ~flush_i;
                accept         = miss_req_rdy_o & (dtlb_miss_req_vld_i | itlb_miss_req_vld_i);
                if (accept) begin
                    state_d = PTW_RSP_ISSUE;
                end
            end
            PTW_RSP_ISSUE: begin
                ptw_req_vld_o = 1'b1;
                if (flush_i) begin
                    state_d = PTW_RSP_IDLE;
                end else if (ptw_req_rdy_i) begin
                    state_d = PTW_RSP_WAIT;
                end
            end
            PTW_RSP_WAIT: begin
                if (ptw_resp_vld_i) begin
                    resp_take = 1'b1;
                    killed_d  = 1'b0;
                    state_d   = (killed_q | flush_i) ? PTW_RSP_IDLE : PTW_RSP_RESP;
                end else if (flush_i) begin
                    killed_d = 1'b1;
                end
            end
            PTW_RSP_RESP: begin
                dtlb_miss_resp_vld_o = ~flush_i & (src_q == TLB_SRC_D);
                itlb_miss_resp_vld_o = ~flush_i & (src_q == TLB_SRC_I);
                state_d              = PTW_RSP_IDLE;
            end
            default: state_d = PTW_RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= PTW_RSP_IDLE;
            killed_q <= 1'b0;
            src_q    <= TLB_SRC_D;
            vpn_q    <= '0;
            ppn_q    <= '0;
            attr_q   <= '0;
            lvl_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            if (accept) begin
                src_q <= dtlb_miss_req_vld_i ? TLB_SRC_D : TLB_SRC_I;
                vpn_q <= dtlb_miss_req_vld_i ? dtlb_miss_req_vpn_i : itlb_miss_req_vpn_i;
            end
            if (resp_take) begin
                ppn_q   <= ptw_resp_ppn_i;
                attr_q  <= ptw_resp_attr_i;
                lvl_q   <= ptw_resp_lvl_i;
                fault_q <= ptw_resp_fault_i;
            end
        end
    end

    assign ptw_req_vpn_o     = vpn_q;
    assign miss_resp_ppn_o   = ppn_q;
    assign miss_resp_attr_o  = attr_q;
    assign miss_resp_lvl_o   = lvl_q;
    assign miss_resp_fault_o = fault_q;
    assign busy_o            = (state_q != PTW_RSP_IDLE);

    a_req_onehot: assert property (@(posedge clk) disable iff (!rstn)
        !(dtlb_miss_req_vld_i && itlb_miss_req_vld_i));

    a_resp_in_wait: assert property (@(posedge clk) disable iff (!rstn)
        ptw_resp_vld_i |-> (state_q == PTW_RSP_WAIT));

endmodule

// File: tb/tb_rvh_ptw_miss_responder.sv
// Scoreboard bench for rvh_ptw_miss_responder: walks are scripted per
// cycle, expected TLB results are queued and checked by a separate monitor.
module tb_rvh_ptw_miss_responder;

    localparam int VW = 27;
    localparam int PW = 44;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush_i = 1'b0;
    logic          dvld = 1'b0;
    logic [VW-1:0] dvpn = '0;
    logic          ivld = 1'b0;
    logic [VW-1:0] ivpn = '0;
    logic          ptw_req_rdy = 1'b0;
    logic          ptw_resp_vld = 1'b0;
    logic [PW-1:0] rppn = '0;
    logic [AW-1:0] rattr = '0;
    logic [1:0]    rlvl = '0;
    logic          rfault = 1'b0;

    logic          miss_req_rdy_o;
    logic          ptw_req_vld_o;
    logic [VW-1:0] ptw_req_vpn_o;
    logic          dresp, iresp;
    logic [PW-1:0] out_ppn;
    logic [AW-1:0] out_attr;
    logic [1:0]    out_lvl;
    logic          out_fault;
    logic          busy_o;

    rvh_ptw_miss_responder #(.VPN_WIDTH(VW), .PPN_WIDTH(PW), .ATTR_WIDTH(AW)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .flush_i             (flush_i),
        .dtlb_miss_req_vld_i (dvld),
        .dtlb_miss_req_vpn_i (dvpn),
        .itlb_miss_req_vld_i (ivld),
        .itlb_miss_req_vpn_i (ivpn),
        .miss_req_rdy_o      (miss_req_rdy_o),
        .ptw_req_vld_o       (ptw_req_vld_o),
        .ptw_req_vpn_o       (ptw_req_vpn_o),
        .ptw_req_rdy_i       (ptw_req_rdy),
        .ptw_resp_vld_i      (ptw_resp_vld),
        .ptw_resp_ppn_i      (rppn),
        .ptw_resp_attr_i     (rattr),
        .ptw_resp_lvl_i      (rlvl),
        .ptw_resp_fault_i    (rfault),
        .dtlb_miss_resp_vld_o(dresp),
        .itlb_miss_resp_vld_o(iresp),
        .miss_resp_ppn_o     (out_ppn),
        .miss_resp_attr_o    (out_attr),
        .miss_resp_lvl_o     (out_lvl),
        .miss_resp_fault_o   (out_fault),
        .busy_o              (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            src;   // 0 = DTLB, 1 = ITLB
        logic [PW-1:0] ppn;
        logic [AW-1:0] attr;
        logic [1:0]    lvl;
        logic          fault;
    } resp_t;

    resp_t sb[$];
    resp_t mon_e;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic resp_t rand_resp();
        resp_t r;
        r.src   = 1'b0;
        r.ppn   = PW'({$urandom, $urandom});
        r.attr  = AW'($urandom);
        r.lvl   = 2'($urandom_range(2, 0));
        r.fault = 1'($urandom_range(1, 0));
        return r;
    endfunction

    // Monitor: every TLB result pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rstn && (dresp || iresp)) begin
            chk("resp_onehot", 64'(dresp & iresp), 0);
            chk("resp_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("resp_src", 64'(iresp), 64'(mon_e.src));
                chk("resp_ppn", out_ppn, mon_e.ppn);
                chk("resp_attr", out_attr, mon_e.attr);
                chk("resp_lvl", out_lvl, mon_e.lvl);
                chk("resp_fault", out_fault, mon_e.fault);
            end
        end
    end

    // mode: 0 normal, 1 flush in ISSUE, 2 flush in WAIT, 3 flush with resp, 4 flush in RESP.
    // pre: request already raised by a previous walk; chain: raise an ITLB request after accept.
    task automatic walk(input bit src, input logic [VW-1:0] vpn, input int rdy_dly,
                        input int rsp_dly, input int mode, input bit pre, input bit chain,
                        input logic [VW-1:0] nvpn, input resp_t r);
        bit expect_pulse;
        int flush_at;
        expect_pulse = (mode == 0);
        flush_at     = $urandom_range(rsp_dly - 1, 0);

        tick();
        flush_i = 1'b0; ptw_req_rdy = 1'b0; ptw_resp_vld = 1'b0;
        if (!pre) begin
            if (src) begin ivld = 1'b1; ivpn = vpn; end
            else     begin dvld = 1'b1; dvpn = vpn; end
        end
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("idle_rdy", miss_req_rdy_o, 1);
        chk("idle_ptw_vld", ptw_req_vld_o, 0);

        tick();
        dvld = 1'b0; ivld = 1'b0;
        if (chain) begin ivld = 1'b1; ivpn = nvpn; end
        @(negedge clk);
        chk("issue_vld", ptw_req_vld_o, 1);
        chk("issue_vpn", ptw_req_vpn_o, vpn);
        chk("issue_rdy", miss_req_rdy_o, 0);
        chk("issue_busy", busy_o, 1);

        repeat (rdy_dly) begin
            tick();
            @(negedge clk);
            chk("hold_vld", ptw_req_vld_o, 1);
            chk("hold_vpn", ptw_req_vpn_o, vpn);
            chk("hold_rdy", miss_req_rdy_o, 0);
        end

        if (mode == 1) begin
            tick();
            flush_i = 1'b1;
            @(negedge clk);
            chk("flush_issue_rdy", miss_req_rdy_o, 0);
            tick();
            flush_i = 1'b0;
            @(negedge clk);
            chk("flush_issue_vld", ptw_req_vld_o, 0);
            chk("flush_issue_busy", busy_o, 0);
            return;
        end

        tick();
        ptw_req_rdy = 1'b1;
        @(negedge clk);
        chk("hs_vld", ptw_req_vld_o, 1);

        for (int i = 0; i < rsp_dly; i++) begin
            tick();
            ptw_req_rdy = 1'b0;
            flush_i = (mode == 2 && i == flush_at);
            @(negedge clk);
            chk("wait_vld", ptw_req_vld_o, 0);
            chk("wait_busy", busy_o, 1);
            chk("wait_nopulse", 64'(dresp | iresp), 0);
        end

        tick();
        flush_i = (mode == 3);
        ptw_resp_vld = 1'b1;
        rppn = r.ppn; rattr = r.attr; rlvl = r.lvl; rfault = r.fault;
        r.src = src;
        if (expect_pulse) sb.push_back(r);
        @(negedge clk);
        chk("resp_early", 64'(dresp | iresp), 0);

        tick();
        ptw_resp_vld = 1'b0;
        flush_i = (mode == 4);
        rppn = PW'({$urandom, $urandom}); rattr = AW'($urandom); rlvl = 2'($urandom); rfault = ~r.fault;
        @(negedge clk);
        chk("resp_latency", 64'(dresp | iresp), 64'(expect_pulse));
        chk("resp_busy", busy_o, 64'(mode == 0 || mode == 4));
    endtask

    task automatic reset_mid_walk();
        tick();
        flush_i = 1'b0; dvld = 1'b1; dvpn = 27'h4321;
        tick();
        dvld = 1'b0; ptw_req_rdy = 1'b1;
        tick();
        ptw_req_rdy = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", busy_o, 1);
        tick();
        rstn = 1'b0;
        #1;
        chk("rst_rdy", miss_req_rdy_o, 0);
        chk("rst_ptw_vld", ptw_req_vld_o, 0);
        chk("rst_ptw_vpn", ptw_req_vpn_o, 0);
        chk("rst_resp", 64'(dresp | iresp), 0);
        chk("rst_ppn", out_ppn, 0);
        chk("rst_attr", out_attr, 0);
        chk("rst_lvl", out_lvl, 0);
        chk("rst_fault", out_fault, 0);
        chk("rst_busy", busy_o, 0);
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    initial begin
        resp_t r, r2;
        bit    src, chain;
        int    m, mode;
        logic [VW-1:0] vpn, nvpn;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_ptw_vld", ptw_req_vld_o, 0);
        chk("reset_rdy", miss_req_rdy_o, 0);
        chk("reset_resp", 64'(dresp | iresp), 0);
        chk("reset_vpn", ptw_req_vpn_o, 0);
        tick();
        rstn = 1'b1;

        r = rand_resp(); r.ppn = 44'hABC; r.lvl = 2'd0; r.fault = 1'b0;
        walk(1'b0, 27'h1234, 0, 5, 0, 1'b0, 1'b0, '0, r);
        r = rand_resp(); r.fault = 1'b1;
        walk(1'b1, 27'h7, 2, 3, 0, 1'b0, 1'b0, '0, r);
        walk(1'b0, 27'h0ABCDE, 1, 4, 2, 1'b0, 1'b0, '0, rand_resp());
        walk(1'b0, 27'h2222, 0, 2, 0, 1'b0, 1'b0, '0, rand_resp());
        walk(1'b1, 27'h3333, 1, 3, 1, 1'b0, 1'b0, '0, rand_resp());
        walk(1'b0, 27'h5555, 0, 2, 3, 1'b0, 1'b0, '0, rand_resp());
        walk(1'b1, 27'h6666, 0, 1, 4, 1'b0, 1'b0, '0, rand_resp());
        reset_mid_walk();
        walk(1'b0, 27'h100, 1, 2, 0, 1'b0, 1'b1, 27'h200, rand_resp());
        walk(1'b1, 27'h200, 0, 3, 0, 1'b1, 1'b0, '0, rand_resp());

        for (int n = 0; n < 40; n++) begin
            src  = 1'($urandom_range(1, 0));
            m    = $urandom_range(9, 0);
            mode = (m < 6) ? 0 : m - 5;
            vpn  = VW'($urandom);
            nvpn = VW'($urandom);
            chain = !src && (mode == 0 || mode == 4) && ($urandom_range(3, 0) == 0);
            walk(src, vpn, $urandom_range(3, 0), $urandom_range(6, 1), mode, 1'b0, chain, nvpn, rand_resp());
            if (chain) begin
                m  = $urandom_range(9, 0);
                r2 = rand_resp();
                walk(1'b1, nvpn, $urandom_range(3, 0), $urandom_range(6, 1), (m < 6) ? 0 : m - 5,
                     1'b1, 1'b0, '0, r2);
            end
        end

        repeat (3) tick();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
